// File: rtl/joy_pad_responder.sv
// Pad-side emulation of the select-multiplexed 3/6-button DB9 protocol.
// Drives the data lines from button state according to select-edge history.
module joy_pad_responder #(
  parameter int SIX_BUTTON     = 1,
  parameter int TIMEOUT_CYCLES = 42000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       sel,
  input  logic [7:0] buttons,
  input  logic [3:0] buttons_ext,
  output logic [5:0] pad_out,
  output logic [2:0] seq_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] SEQ_MAX = (SIX_BUTTON != 0) ? 3'd4 : 3'd2;
  localparam logic [TW-1:0] T_SAT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_EXP = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sel_d_q, sel_d_d;
  logic [2:0]             seq_q, seq_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [5:0]             pad_q, pad_d;

  logic sel_s, fall, rise, edge_any, expire;
  logic u, d, l, r, b, c, a, s;
  logic x, y, z, mode;

  assign sel_s    = sync_q[SYNC_STAGES-1];
  assign fall     = sel_d_q & ~sel_s;
  assign rise     = ~sel_d_q & sel_s;
  assign edge_any = fall | rise;
  assign expire   = (tmr_q == T_EXP) & ~edge_any;

  assign {s, a, c, b, r, l, d, u} = buttons;
  assign {mode, z, y, x}          = buttons_ext;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sel};
    sel_d_d = sel_s;
    tmr_d   = tmr_q;
    seq_d   = seq_q;
    if (edge_any)
      tmr_d = '0;
    else if (tmr_q != T_SAT)
      tmr_d = tmr_q + 1'b1;
    unique case (1'b1)
      fall: if (seq_q != SEQ_MAX) seq_d = seq_q + 3'd1;
      expire: seq_d = 3'd0;
      default: ;
    endcase
  end

  // Pins 3/4 low while select is low identify a connected pad.
  always_comb begin
    pad_d = {c, b, r, l, d, u};
    unique case (1'b1)
      sel_s && (seq_q == 3'd3):  pad_d = {c, b, mode, x, y, z};
      sel_s && (seq_q != 3'd3):  pad_d = {c, b, r, l, d, u};
      !sel_s && (seq_q == 3'd3): pad_d = {s, a, 4'b0000};
      !sel_s && (seq_q == 3'd4): pad_d = {s, a, 4'b1111};
      default:                   pad_d = {s, a, 2'b00, d, u};
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '1;
      sel_d_q <= 1'b1;
      seq_q   <= 3'd0;
      tmr_q   <= '0;
      pad_q   <= 6'b111111;
    end else begin
      sync_q  <= sync_d;
      sel_d_q <= sel_d_d;
      seq_q   <= seq_d;
      tmr_q   <= tmr_d;
      pad_q   <= pad_d;
    end
  end

  assign pad_out   = pad_q;
  assign seq_state = seq_q;

endmodule

// File: tb/tb_joy_pad_responder.sv
// Scoreboard bench for joy_pad_responder: three parameter variants share
// one stimulus stream; a phase-level pad model predicts settled outputs.
module tb_joy_pad_responder;

  localparam int T = 200;

  logic       clk;
  logic       reset_n;
  logic       sel;
  logic [7:0] buttons;
  logic [3:0] ext;
  logic [5:0] pad [3];
  logic [2:0] sq  [3];

  int maxc [3] = '{4, 2, 4};
  int sync [3] = '{2, 2, 3};

  joy_pad_responder #(.SIX_BUTTON(1), .TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) u0 (
    .clk_sys(clk), .reset_n(reset_n), .sel(sel), .buttons(buttons),
    .buttons_ext(ext), .pad_out(pad[0]), .seq_state(sq[0]));
  joy_pad_responder #(.SIX_BUTTON(0), .TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) u1 (
    .clk_sys(clk), .reset_n(reset_n), .sel(sel), .buttons(buttons),
    .buttons_ext(ext), .pad_out(pad[1]), .seq_state(sq[1]));
  joy_pad_responder #(.SIX_BUTTON(1), .TIMEOUT_CYCLES(T), .SYNC_STAGES(3)) u2 (
    .clk_sys(clk), .reset_n(reset_n), .sel(sel), .buttons(buttons),
    .buttons_ext(ext), .pad_out(pad[2]), .seq_state(sq[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         inst;
    int         at;
    logic [5:0] pad;
    logic [2:0] seq;
    string      tag;
  } item_t;

  item_t q[$];
  int nchecks = 0;
  int nerr = 0;

  // Reference model state: edges counted per variant since the last timeout.
  int   cnt [3];
  int   last_edge;
  logic cur_lvl;

  function automatic logic [5:0] exp_pad(logic lvl, int c,
                                         logic [7:0] bt, logic [3:0] e);
    logic u, d, l, r, b, cc, a, s, x, y, z, m;
    {s, a, cc, b, r, l, d, u} = bt;
    {m, z, y, x} = e;
    if (lvl) return (c == 3) ? {cc, b, m, x, y, z} : {cc, b, r, l, d, u};
    if (c == 3) return {s, a, 4'b0000};
    if (c == 4) return {s, a, 4'b1111};
    return {s, a, 2'b00, d, u};
  endfunction

  task automatic chk(string tag, int i, logic [5:0] ap, logic [2:0] as,
                     logic [5:0] ep, logic [2:0] es);
    nchecks++;
    if (ap !== ep || as !== es) begin
      nerr++;
      $display("FAIL %s inst%0d: got pad=%b seq=%0d, expected pad=%b seq=%0d",
               tag, i, ap, as, ep, es);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      item_t it;
      it = q.pop_front();
      if (it.at < cyc) begin
        nchecks++;
        nerr++;
        $display("FAIL %s inst%0d: sample missed at cycle %0d", it.tag,
                 it.inst, cyc);
      end else begin
        chk(it.tag, it.inst, pad[it.inst], sq[it.inst], it.pad, it.seq);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    last_edge = cyc;
    cur_lvl = sel;
  endtask

  // Drive one select phase of L cycles and predict the outputs at its end.
  task automatic phase(input logic lvl, input int L, input logic [7:0] bt,
                       input logic [3:0] e, input string tag);
    int since;
    sel = lvl;
    buttons = bt;
    ext = e;
    if (lvl != cur_lvl) begin
      for (int i = 0; i < 3; i++) begin
        if (cyc - last_edge > T) cnt[i] = 0;
        if (!lvl && cnt[i] < maxc[i]) cnt[i]++;
      end
      last_edge = cyc;
      cur_lvl = lvl;
    end
    since = cyc + L - last_edge;
    for (int i = 0; i < 3; i++) begin
      item_t it;
      int cp, cs;
      cp = (since >= T + sync[i] + 2) ? 0 : cnt[i];
      cs = (since >= T + sync[i] + 1) ? 0 : cnt[i];
      it.inst = i;
      it.at = cyc + L;
      it.pad = exp_pad(lvl, cp, bt, e);
      it.seq = 3'(cs);
      it.tag = tag;
      q.push_back(it);
    end
    repeat (L) @(negedge clk);
  endtask

  task automatic measure();
    logic [5:0] old [3];
    int lat [3];
    for (int i = 0; i < 3; i++) begin
      old[i] = pad[i];
      lat[i] = -1;
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        if (lat[i] < 0 && pad[i] != old[i]) lat[i] = k;
    end
    for (int i = 0; i < 3; i++) begin
      nchecks++;
      if (lat[i] != sync[i] + 1) begin
        nerr++;
        $display("FAIL latency inst%0d: got %0d cycles, expected %0d",
                 i, lat[i], sync[i] + 1);
      end
    end
  endtask

  initial begin
    clk = 0;
    reset_n = 1;
    sel = 1;
    buttons = 8'hFE;
    ext = 4'hF;
    #1 reset_n = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("reset_hold", i, pad[i], sq[i], 6'b111111, 3'd0);
    reset_n = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      item_t it;
      it.inst = i;
      it.at = cyc + 1;
      it.pad = 6'b111110;
      it.seq = 3'd0;
      it.tag = "reset_release";
      q.push_back(it);
    end
    @(negedge clk);

    phase(1, 10, 8'h7F, 4'hE, "pre_high");
    fork
      measure();
    join_none
    phase(0, 100, 8'h7F, 4'hE, "low1");
    phase(1, 100, 8'h7F, 4'hE, "high1");
    phase(0, 100, 8'h7F, 4'hE, "low2");
    phase(1, 100, 8'h7F, 4'hE, "high2");
    phase(0, 100, 8'h7F, 4'hE, "low3");
    phase(1, 100, 8'h7F, 4'hE, "high3");
    phase(0, 100, 8'h7F, 4'hE, "low4");
    phase(1, T + 10, 8'h7F, 4'hE, "idle_timeout");
    phase(0, 100, 8'h7F, 4'hE, "low_after_timeout");

    phase(1, T, 8'h7F, 4'hE, "gap_t_high");
    phase(0, 50, 8'h7F, 4'hE, "gap_t_low");
    phase(1, T + 1, 8'h7F, 4'hE, "gap_t1_high");
    phase(0, 50, 8'h7F, 4'hE, "gap_t1_low");

    for (int n = 0; n < 40; n++)
      phase(~cur_lvl, $urandom_range(6, 60), 8'($urandom), 4'($urandom),
            "random");

    phase(1, T + 10, 8'hA5, 4'h5, "idle2");
    phase(0, 30, 8'hA5, 4'h5, "mid_low1");
    phase(1, 30, 8'hA5, 4'h5, "mid_high1");
    phase(0, 30, 8'hA5, 4'h5, "mid_low2");
    phase(1, 30, 8'hA5, 4'h5, "mid_high2");
    phase(0, 30, 8'hA5, 4'h5, "mid_low3");
    phase(1, 20, 8'hA5, 4'h5, "mid_high3");
    #2 reset_n = 0;
    #1;
    for (int i = 0; i < 3; i++)
      chk("async_reset", i, pad[i], sq[i], 6'b111111, 3'd0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    model_reset();
    phase(1, 10, 8'h3C, 4'hA, "post_reset_high");
    phase(0, 30, 8'h3C, 4'hA, "post_reset_low");
    phase(1, 30, 8'h3C, 4'hA, "post_reset_high2");

    repeat (5) @(negedge clk);
    nchecks++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending samples, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/joy_pad_responder.md
Name: joy_pad_responder

Overview:
- Emulates the pad side of the DB9 select-multiplexed protocol (Sega 3/6-button pad).
- Drives the six shared DB9 data lines from an internal 12-button state, according to the level and edge history of the select line.
- It is the counterpart of the board-side joystick decoder that drives joy_c as select and samples the data lines.
- Used for loopback tests, and for presenting keyboard/USB-derived pad state to an external console port.

Parameters:
- SIX_BUTTON, 1, 1 = full 6-button ID/extra-button sequence; 0 = plain 3-button pad (edge counter never exceeds 2).
- TIMEOUT_CYCLES, 42000, clk_sys cycles without any select edge before the sequence counter returns to 0 (1.5 ms at 28 MHz).
- SYNC_STAGES, 2, select-line synchroniser depth (legal range 2..3).

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sel  in  1  select line from the host; asynchronous to clk_sys.
- buttons  in  8  SACBRLDU, active = 0 (bit0 U … bit7 S).
- buttons_ext  in  4  {Mode,Z,Y,X}, active = 0 (bit0 X … bit3 Mode).
- pad_out  out  6  DB9 lines, active = 0: bit0 pin1, bit1 pin2, bit2 pin3, bit3 pin4, bit4 pin6, bit5 pin9.
- seq_state  out  3  debug: current edge count (0..4).

Behaviour:
- Reset:
  - All sync flops = 1, so sel is treated as high.
  - seq_state = 0, timeout counter = 0.
  - pad_out = 6'b111111.
  - Reset asserted mid-sequence aborts it immediately with the same values.
- Synchroniser: sel passes through SYNC_STAGES flops to give sel_s; sel_d is sel_s delayed one cycle.
  - fall = sel_d & ~sel_s; rise = ~sel_d & sel_s.
- Sequence counter (seq_state):
  - On fall: increment, saturating at 4 (SIX_BUTTON=1) or 2 (SIX_BUTTON=0).
  - On rise: unchanged.
- Timeout:
  - Counter clears on any fall or rise; otherwise increments, saturating at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES-1 with no edge that cycle, seq_state <= 0 on the next edge of clk_sys.
  - An edge and timeout expiry in the same cycle: the edge wins (count updates, timer clears).
- Output map (registered; selected from the sel_s and seq_state values of the current cycle, appears on pad_out the next cycle):
  - sel_s=1, seq 0,1,2,4: {C,B,R,L,D,U}.
  - sel_s=1, seq 3: {C,B,Mode,X,Y,Z}, i.e. pin1=Z, pin2=Y, pin3=X, pin4=Mode.
  - sel_s=0, seq 0,1,2: {S,A,0,0,D,U}. Pins 3/4 are forced to 0, which is the pad-present ID.
  - sel_s=0, seq 3: {S,A,0,0,0,0}. This is the 6-button ID.
  - sel_s=0, seq 4: {S,A,1,1,1,1}.
- Latency: sel pin change to pad_out change = SYNC_STAGES+1 clk_sys cycles. The host must allow at least this settle time before sampling.
- Button inputs are sampled every cycle, with no debounce. A button change is visible on pad_out after 1 cycle when the current mapping includes that button.
- Counter behaviour:
  - Counter at 4 with further falls: stays at 4 and keeps outputting the seq-4 mapping until timeout.
  - seq 0 with sel low (power-up with sel low, or after timeout while sel is low): outputs the seq 0..2 low mapping.
- seq_state is exported as a registered value.

Test Plan:
- Reset with sel=1 and buttons=8'hFE (U pressed) → pad_out=6'b111111 during reset. Release reset → pad_out=6'b111110 within 1 cycle of release, seq_state=0.
- SIX_BUTTON=1, buttons=8'h7F (S), buttons_ext=4'hE (X). Toggle sel low/high every 100 cycles: 4 lows, 3 highs, then sel returns high.
  - Low 1: pad_out=6'b010011. Low 2: 6'b010011. Low 3: 6'b010000. Low 4: 6'b011111.
  - High after low 3: 6'b111011 (X on pin3).
  - All other highs: 6'b111111.
- Idle TIMEOUT_CYCLES+5 cycles after the sequence → seq_state=0. The next low phase gives 6'b010011 again, not the ID pattern.
- SIX_BUTTON=0, same toggling → seq_state never exceeds 2, pad_out never shows the seq-3 or seq-4 patterns.
- Sel edge on exactly cycle TIMEOUT_CYCLES-1 of idle → count increments from its prior value and is not cleared. Pulse reset_n low mid-sequence at seq 3 → seq_state=0, pad_out=6'b111111 asynchronously.
- Measure sel falling at the pin to pad_out change → exactly SYNC_STAGES+1 cycles, for both SYNC_STAGES=2 and SYNC_STAGES=3.
